// File: rtl/core_ctrl_pkg.sv
// Shared control-path definitions: redirect FSM state encoding and PC width.
package core_ctrl_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } redir_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, hold at all-ones, or step by one.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/redirect_control.sv
// Branch-mispredict redirect controller: flush/stall sequencing and fetch redirect handshake.
// Define REDIRECT_STATS_EN to build the resolved-branch and mispredict counters.
module redirect_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_BrValid_1,
  input  logic             i_Jump_1,
  input  logic             i_Predicted_1,
  input  logic [PC_W-1:0]  i_Target_32,
  input  logic [PC_W-1:0]  i_FallThrough_32,
  input  logic             i_RedirReady_1,
  output logic             o_RedirValid_1,
  output logic [PC_W-1:0]  o_RedirPC_32,
  output logic             o_Flush_1,
  output logic             o_Stall_1,
  output logic [CNT_W-1:0] o_BrCnt_CNT_W,
  output logic [CNT_W-1:0] o_MispredCnt_CNT_W
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  redir_state_e    state_q;
  redir_state_e    state_d;
  logic [2:0]      drain_q;
  logic [2:0]      drain_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            mispredict_s;

  assign mispredict_s = i_BrValid_1 & (i_Jump_1 != i_Predicted_1);

  // State, drain count and redirect PC registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      drain_q <= 3'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic; branch inputs only matter in IDLE, later ones are wrong-path.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict_s) begin
          state_d = REDIRECT;
          pc_d    = i_Jump_1 ? i_Target_32 : i_FallThrough_32;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (i_RedirReady_1) begin
          if (FLUSH_INIT == 3'd0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drain_d = FLUSH_INIT;
          end
        end else begin
          state_d = REDIRECT;
        end
      end
      DRAIN: begin
        drain_d = (drain_q == 3'd0) ? 3'd0 : drain_q - 3'd1;
        if (drain_q <= 3'd1) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        drain_d = 3'd0;
      end
    endcase
  end

  // Output decode; the IDLE flush is combinational so the bad instruction dies this cycle.
  always_comb begin
    o_RedirValid_1 = 1'b0;
    o_Flush_1      = 1'b0;
    o_Stall_1      = 1'b0;
    case (state_q)
      IDLE: begin
        o_Flush_1 = mispredict_s;
      end
      REDIRECT: begin
        o_RedirValid_1 = 1'b1;
        o_Flush_1      = 1'b1;
        o_Stall_1      = 1'b1;
      end
      DRAIN: begin
        o_Flush_1 = 1'b1;
      end
      default: begin
        o_Flush_1 = 1'b0;
      end
    endcase
  end

  assign o_RedirPC_32 = pc_q;

`ifdef REDIRECT_STATS_EN
  logic br_inc_s;
  logic mis_inc_s;

  assign br_inc_s  = (state_q == IDLE) & i_BrValid_1;
  assign mis_inc_s = (state_q == IDLE) & mispredict_s;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk_i   (i_Clk),
    .clr_i   (i_Rst),
    .inc_i   (br_inc_s),
    .count_o (o_BrCnt_CNT_W)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk_i   (i_Clk),
    .clr_i   (i_Rst),
    .inc_i   (mis_inc_s),
    .count_o (o_MispredCnt_CNT_W)
  );
`else
  assign o_BrCnt_CNT_W      = '0;
  assign o_MispredCnt_CNT_W = '0;
`endif

endmodule

// File: tb/tb_redirect_control.sv
// Self-checking bench for redirect_control: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the redirect protocol.
module tb_redirect_control;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          bv;
  logic          jmp;
  logic          pred;
  logic [31:0]   tgt;
  logic [31:0]   ft;
  logic          rdy;
  logic          redir_valid;
  logic [31:0]   redir_pc;
  logic          flush;
  logic          stall;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] mis_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: pending redirect, flush cycles still owed, and statistics.
  bit          m_wait;
  int          m_drain;
  logic [31:0] m_pc;
  int          m_br;
  int          m_mis;

  always #5 clk = ~clk;

  redirect_control #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_Clk              (clk),
    .i_Rst              (rst),
    .i_BrValid_1        (bv),
    .i_Jump_1           (jmp),
    .i_Predicted_1      (pred),
    .i_Target_32        (tgt),
    .i_FallThrough_32   (ft),
    .i_RedirReady_1     (rdy),
    .o_RedirValid_1     (redir_valid),
    .o_RedirPC_32       (redir_pc),
    .o_Flush_1          (flush),
    .o_Stall_1          (stall),
    .o_BrCnt_CNT_W      (br_cnt),
    .o_MispredCnt_CNT_W (mis_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic b, input logic j, input logic p,
                      input logic [31:0] t, input logic [31:0] f, input logic rd);
    bit mis;
    bit idle;
    @(negedge clk);
    rst = r; bv = b; jmp = j; pred = p; tgt = t; ft = f; rdy = rd;
    #1;
    mis  = b && (j != p);
    idle = !m_wait && (m_drain == 0);
    chk("valid", {31'd0, redir_valid}, {31'd0, m_wait});
    chk("stall", {31'd0, stall}, {31'd0, m_wait});
    chk("flush", {31'd0, flush}, {31'd0, (!idle || mis)});
    chk("pc", redir_pc, m_pc);
    chk("brcnt", {28'd0, br_cnt}, STATS ? m_br : 0);
    chk("miscnt", {28'd0, mis_cnt}, STATS ? m_mis : 0);
    @(posedge clk);
    if (r) begin
      m_wait = 1'b0; m_drain = 0; m_pc = 32'd0; m_br = 0; m_mis = 0;
    end else if (m_wait) begin
      if (rd) begin
        m_wait  = 1'b0;
        m_drain = FC;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else begin
      if (b) m_br = sat_inc(m_br);
      if (mis) begin
        m_mis  = sat_inc(m_mis);
        m_wait = 1'b1;
        m_pc   = j ? t : f;
      end
    end
  endtask

  task automatic idle_step(input logic rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
  endtask

  initial begin
    rst = 1'b1; bv = 1'b0; jmp = 1'b0; pred = 1'b0; tgt = 32'd0; ft = 32'd0; rdy = 1'b0;
    m_wait = 1'b0; m_drain = 0; m_pc = 32'd0; m_br = 0; m_mis = 0;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle_step(1'b0);
    chk("rst_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_pc", redir_pc, 32'd0);

    // Taken mispredict with ready already high: flush T, valid T+1, drain two, idle T+4.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1040, 32'h0000_0FFC, 1'b1);
    #1;
    chk("t1_valid", {31'd0, redir_valid}, 32'd1);
    chk("t1_pc", redir_pc, 32'h0000_1040);
    idle_step(1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    #1;
    chk("t4_flush", {31'd0, flush}, 32'd0);

    // Not-taken mispredict with ready low for three cycles, then one late branch ignored.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_2004, 1'b0);
    idle_step(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_5550, 32'h0000_5554, 1'b0);
    idle_step(1'b0);
    #1;
    chk("held_pc", redir_pc, 32'h0000_2004);
    chk("held_stall", {31'd0, stall}, 32'd1);
    idle_step(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_7004, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_8000, 32'h0000_8004, 1'b1);
    #1;
    chk("drain_pc", redir_pc, 32'h0000_2004);

    // Correct prediction: no flush, branch count only.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_9004, 1'b1);
    idle_step(1'b1);

    // Reset while a redirect waits on a low ready.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_A000, 32'h0000_A004, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle_step(1'b0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_br", {28'd0, br_cnt}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
           1'($urandom), $urandom, $urandom, ($urandom_range(0, 2) != 0));
    end

    // Saturation: twenty mispredicts from a clean start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom, 1'b1);
      idle_step(1'b1);
      idle_step(1'b0);
      idle_step(1'b0);
    end
    idle_step(1'b0);
    chk("sat_br", {28'd0, br_cnt}, STATS ? 32'd15 : 32'd0);
    chk("sat_mis", {28'd0, mis_cnt}, STATS ? 32'd15 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
